func_sweep_ctrl: RTL and testbench

Sequencer that drives the four inputs A, B, C, D of the `func` combinational block through all 16 input combinations, samples `out` for each one, and assembles a 16-bit truth-table word. It compares the word against an expected value latched at start and reports pass/fail, mismatch count and first mismatching index. It sits between a host/bench and `func`, replacing hand-written per-vector stimulus with a single start/done handshake.

---
 rtl/func_sweep_pkg.sv | 14 +
 rtl/func_sweep_ctrl.sv | 114 +++++++++++
 tb/tb_func_sweep_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/func_sweep_pkg.sv
// Shared constants and state encoding for the func truth-table sweep controller.
package func_sweep_pkg;

    localparam int NUM_VEC = 16;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/func_sweep_ctrl.sv
// Steps {A,B,C,D} through all 16 vectors, samples out per vector and compares
// the assembled truth word against the expected word latched at start.
//
// state | meaning
// IDLE  | waiting for start; results hold from the last sweep
// RUN   | holding vector idx for SETTLE+1 cycles, sampling on the last one
// DONE  | one-cycle done pulse; start ignored
module func_sweep_ctrl
    import func_sweep_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        out,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_bad
);

    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_VEC-1:0]   shadow;
    logic [NUM_VEC-1:0]   exp_lat;
    logic [NUM_VEC-1:0]   final_word;
    logic [NUM_VEC-1:0]   diff;
    logic [4:0]           pop;
    logic [3:0]           fb;

    // Results are computed from the word as it will be once the current sample lands,
    // so they can be published on the same edge as the last sample.
    always_comb begin
        final_word      = shadow;
        final_word[idx] = out;
        diff            = final_word ^ exp_lat;
        pop             = '0;
        fb              = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            pop = pop + 5'(diff[i]);
            if (diff[i]) fb = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            shadow    <= '0;
            exp_lat   <= '0;
            {A, B, C, D} <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            truth     <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            first_bad <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_lat      <= expected;
                        shadow       <= '0;
                        idx          <= '0;
                        cnt          <= '0;
                        {A, B, C, D} <= 4'b0000;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (cnt != SETTLE_C) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        shadow[idx] <= out;
                        cnt         <= '0;
                        if (idx != LAST_IDX) begin
                            idx          <= idx + 1'b1;
                            {A, B, C, D} <= idx + 1'b1;
                        end else begin
                            {A, B, C, D} <= 4'b0000;
                            busy      <= 1'b0;
                            truth     <= final_word;
                            pass      <= (diff == '0);
                            err_count <= pop;
                            first_bad <= fb;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Scoreboard bench for func_sweep_ctrl with a behavioural func model; a second
// instance runs with SETTLE=0.
module tb_func_sweep_ctrl;

    typedef struct packed {
        logic [15:0] truth;
        logic        pass;
        logic [4:0]  errc;
        logic [3:0]  fb;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start2 = 1'b0;
    logic [15:0] expected = '0, expected2 = '0;
    logic        out;
    int          mode = 0;

    logic        A, B, C, D, busy, done, pass;
    logic [15:0] truth;
    logic [4:0]  err_count;
    logic [3:0]  first_bad;

    logic        A2, B2, C2, D2, busy2, done2, pass2;
    logic [15:0] truth2;
    logic [4:0]  err_count2;
    logic [3:0]  first_bad2;

    res_t sb[$];
    res_t r;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    function automatic logic fmodel(int m, logic [3:0] v);
        case (m)
            0:       return v[3] & v[2];
            1:       return 1'b0;
            default: return (v[3] ^ v[0]) | v[1];
        endcase
    endfunction

    function automatic res_t model_result(int m, logic [15:0] e);
        res_t        x;
        logic [15:0] d;
        x.truth = '0;
        for (int i = 0; i < 16; i++) x.truth[i] = fmodel(m, 4'(i));
        d      = x.truth ^ e;
        x.pass = (d == 16'h0000);
        x.errc = '0;
        x.fb   = '0;
        for (int i = 15; i >= 0; i--) begin
            if (d[i]) begin
                x.errc = x.errc + 5'd1;
                x.fb   = 4'(i);
            end
        end
        return x;
    endfunction

    assign out = fmodel(mode, {A, B, C, D});

    func_sweep_ctrl #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .out(out),
        .A(A), .B(B), .C(C), .D(D), .busy(busy), .done(done), .truth(truth),
        .pass(pass), .err_count(err_count), .first_bad(first_bad)
    );

    func_sweep_ctrl #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected2), .out(1'b0),
        .A(A2), .B(B2), .C(C2), .D(D2), .busy(busy2), .done(done2), .truth(truth2),
        .pass(pass2), .err_count(err_count2), .first_bad(first_bad2)
    );

    // Leaves the caller just after the accept edge (edge 0); the next negedge follows edge 0.
    task automatic do_start(int m, logic [15:0] e);
        @(negedge clk);
        mode = m;
        expected = e;
        start = 1'b1;
        sb.push_back(model_result(m, e));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({A, B, C, D} !== 4'b0000) begin failures++; $display("FAIL reset_drives got=%b exp=0000", {A, B, C, D}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (truth !== 16'h0000) begin failures++; $display("FAIL reset_truth got=%h exp=0000", truth); end
        checks++; if ({pass, err_count, first_bad} !== 10'd0) begin failures++; $display("FAIL reset_results got=%b/%0d/%0d exp=0/0/0", pass, err_count, first_bad); end
        checks++; if ({busy2, done2, truth2} !== 18'd0) begin failures++; $display("FAIL reset_dut0 got=%b/%b/%h exp=0/0/0000", busy2, done2, truth2); end
        rst_n = 1'b1;
    endtask

    task automatic test_pass_sweep();
        do_start(0, 16'hF000);
        for (int k = 0; k <= 49; k++) begin
            @(negedge clk);
            checks++; if (done !== (k == 48)) begin failures++; $display("FAIL pass_done edge=%0d got=%b exp=%b", k, done, k == 48); end
            checks++; if (busy !== (k < 48)) begin failures++; $display("FAIL pass_busy edge=%0d got=%b exp=%b", k, busy, k < 48); end
            if (k == 48) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL pass_sb got=empty exp=entry"); end
                else begin
                    r = sb.pop_front();
                    checks++; if (truth !== r.truth) begin failures++; $display("FAIL pass_truth got=%h exp=%h", truth, r.truth); end
                    checks++; if (pass !== r.pass) begin failures++; $display("FAIL pass_pass got=%b exp=%b", pass, r.pass); end
                    checks++; if (err_count !== r.errc) begin failures++; $display("FAIL pass_errc got=%0d exp=%0d", err_count, r.errc); end
                    checks++; if (first_bad !== r.fb) begin failures++; $display("FAIL pass_fb got=%0d exp=%0d", first_bad, r.fb); end
                end
            end
        end
    endtask

    task automatic test_fail_sweep();
        do_start(0, 16'hF100);
        for (int k = 0; k <= 49; k++) begin
            @(negedge clk);
            checks++; if (done !== (k == 48)) begin failures++; $display("FAIL fail_done edge=%0d got=%b exp=%b", k, done, k == 48); end
            if (k == 48) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL fail_sb got=empty exp=entry"); end
                else begin
                    r = sb.pop_front();
                    checks++; if (truth !== r.truth) begin failures++; $display("FAIL fail_truth got=%h exp=%h", truth, r.truth); end
                    checks++; if (pass !== r.pass) begin failures++; $display("FAIL fail_pass got=%b exp=%b", pass, r.pass); end
                    checks++; if (err_count !== r.errc) begin failures++; $display("FAIL fail_errc got=%0d exp=%0d", err_count, r.errc); end
                    checks++; if (first_bad !== r.fb) begin failures++; $display("FAIL fail_fb got=%0d exp=%0d", first_bad, r.fb); end
                end
            end
        end
    endtask

    task automatic test_drive_order();
        logic [3:0] ev;
        do_start(0, 16'h0F0F);
        for (int k = 0; k <= 48; k++) begin
            @(negedge clk);
            ev = (k < 48) ? 4'(k / 3) : 4'b0000;
            checks++; if ({A, B, C, D} !== ev) begin failures++; $display("FAIL order_vec edge=%0d got=%b exp=%b", k, {A, B, C, D}, ev); end
            if (k == 48) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL order_sb got=empty exp=entry"); end
                else begin
                    r = sb.pop_front();
                    checks++; if ({truth, pass, err_count, first_bad} !== r) begin failures++; $display("FAIL order_result got=%h/%b/%0d/%0d exp=%h/%b/%0d/%0d", truth, pass, err_count, first_bad, r.truth, r.pass, r.errc, r.fb); end
                end
            end
        end
    endtask

    task automatic test_start_ignore();
        do_start(0, 16'hF100);
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            checks++; if (done !== (k == 48)) begin failures++; $display("FAIL ign_done edge=%0d got=%b exp=%b", k, done, k == 48); end
            checks++; if (busy !== (k < 48)) begin failures++; $display("FAIL ign_busy edge=%0d got=%b exp=%b", k, busy, k < 48); end
            if (k == 10 || k == 11) begin
                checks++; if ({A, B, C, D} !== 4'd3) begin failures++; $display("FAIL ign_vec edge=%0d got=%b exp=0011", k, {A, B, C, D}); end
            end
            if (k == 48) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL ign_sb got=empty exp=entry"); end
                else begin
                    r = sb.pop_front();
                    checks++; if ({truth, pass, err_count, first_bad} !== r) begin failures++; $display("FAIL ign_result got=%h/%b/%0d/%0d exp=%h/%b/%0d/%0d", truth, pass, err_count, first_bad, r.truth, r.pass, r.errc, r.fb); end
                end
            end
            start = (k == 9) || (k == 48);
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        mode = 0;
        expected = 16'hF000;
        start = 1'b1;
        sb.push_back(model_result(0, 16'hF000));
        @(posedge clk);
        #1;
        for (int k = 0; k <= 99; k++) begin
            @(negedge clk);
            checks++; if (done !== (k == 48 || k == 98)) begin failures++; $display("FAIL b2b_done edge=%0d got=%b", k, done); end
            checks++; if (busy !== (k < 48 || (k >= 50 && k < 98))) begin failures++; $display("FAIL b2b_busy edge=%0d got=%b", k, busy); end
            if (k == 48 || k == 98) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL b2b_sb edge=%0d got=empty exp=entry", k); end
                else begin
                    r = sb.pop_front();
                    checks++; if ({truth, pass, err_count, first_bad} !== r) begin failures++; $display("FAIL b2b_result edge=%0d got=%h/%b/%0d/%0d exp=%h/%b/%0d/%0d", k, truth, pass, err_count, first_bad, r.truth, r.pass, r.errc, r.fb); end
                end
            end
            if (k == 48) begin
                mode = 2;
                expected = 16'h5A5A;
                sb.push_back(model_result(2, 16'h5A5A));
            end
            if (k == 50) begin
                checks++; if (truth !== 16'hF000) begin failures++; $display("FAIL b2b_hold got=%h exp=f000", truth); end
                checks++; if ({A, B, C, D} !== 4'b0000) begin failures++; $display("FAIL b2b_vec0 got=%b exp=0000", {A, B, C, D}); end
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midsweep();
        do_start(0, 16'hF100);
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            if (k == 21) begin
                checks++; if ({A, B, C, D} !== 4'd7) begin failures++; $display("FAIL rst_vec7 got=%b exp=0111", {A, B, C, D}); end
                rst_n = 1'b0;
            end
            if (k == 22) begin
                checks++; if ({A, B, C, D, busy, done} !== 6'd0) begin failures++; $display("FAIL rst_ctrl got=%b exp=000000", {A, B, C, D, busy, done}); end
                checks++; if (truth !== 16'h0000) begin failures++; $display("FAIL rst_truth got=%h exp=0000", truth); end
                checks++; if ({pass, err_count, first_bad} !== 10'd0) begin failures++; $display("FAIL rst_results got=%b/%0d/%0d exp=0/0/0", pass, err_count, first_bad); end
                sb.delete();
                rst_n = 1'b1;
            end
        end
        do_start(0, 16'hF000);
        for (int k = 0; k <= 48; k++) begin
            @(negedge clk);
            if (k == 0 || k == 3) begin
                checks++; if ({A, B, C, D} !== 4'(k / 3)) begin failures++; $display("FAIL rst_restart_vec edge=%0d got=%b exp=%0d", k, {A, B, C, D}, k / 3); end
            end
            checks++; if (done !== (k == 48)) begin failures++; $display("FAIL rst_done edge=%0d got=%b exp=%b", k, done, k == 48); end
            if (k == 48) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL rst_sb got=empty exp=entry"); end
                else begin
                    r = sb.pop_front();
                    checks++; if ({truth, pass, err_count, first_bad} !== r) begin failures++; $display("FAIL rst_result got=%h/%b/%0d/%0d exp=%h/%b/%0d/%0d", truth, pass, err_count, first_bad, r.truth, r.pass, r.errc, r.fb); end
                end
            end
        end
    endtask

    task automatic test_settle0();
        @(negedge clk);
        expected2 = 16'hFFFF;
        start2 = 1'b1;
        sb.push_back(model_result(1, 16'hFFFF));
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            checks++; if (done2 !== (k == 16)) begin failures++; $display("FAIL s0_done edge=%0d got=%b exp=%b", k, done2, k == 16); end
            checks++; if (busy2 !== (k < 16)) begin failures++; $display("FAIL s0_busy edge=%0d got=%b exp=%b", k, busy2, k < 16); end
            if (k < 16) begin
                checks++; if ({A2, B2, C2, D2} !== 4'(k)) begin failures++; $display("FAIL s0_vec edge=%0d got=%b exp=%0d", k, {A2, B2, C2, D2}, k); end
            end
            if (k == 16) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL s0_sb got=empty exp=entry"); end
                else begin
                    r = sb.pop_front();
                    checks++; if (truth2 !== r.truth) begin failures++; $display("FAIL s0_truth got=%h exp=%h", truth2, r.truth); end
                    checks++; if (pass2 !== r.pass) begin failures++; $display("FAIL s0_pass got=%b exp=%b", pass2, r.pass); end
                    checks++; if (err_count2 !== r.errc) begin failures++; $display("FAIL s0_errc got=%0d exp=%0d", err_count2, r.errc); end
                    checks++; if (first_bad2 !== r.fb) begin failures++; $display("FAIL s0_fb got=%0d exp=%0d", first_bad2, r.fb); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass_sweep();
        test_fail_sweep();
        test_drive_order();
        test_start_ignore();
        test_back_to_back();
        test_reset_midsweep();
        test_settle0();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
